// File: rtl/calc_pkg.sv
// Shared defaults, FSM encoding and sticky error codes for the operand stack.
package calc_pkg;
    localparam int DEPTH_DEF  = 8;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 8;
    localparam int SP_W       = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUSH_WR = 2'd1,
        POP_RD  = 2'd2,
        ERROR   = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UDF  = 2'b10;
    localparam logic [1:0] ERR_CONF = 2'b11;
endpackage

// File: rtl/operand_stack_ctrl.sv
// Stack-pointer controller in front of an external word memory; one request at a
// time, two-cycle push/pop handshakes, sticky error state until clear or reset.
module operand_stack_ctrl
    import calc_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              ready,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic [SP_W-1:0]   depth,
    output logic [1:0]        err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_t          state, state_nxt;
    logic [SP_W-1:0] sp;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (push && pop)  state_nxt = ERROR;
                    else if (push)    state_nxt = full  ? ERROR : PUSH_WR;
                    else if (pop)     state_nxt = empty ? ERROR : POP_RD;
                end
                PUSH_WR, POP_RD: state_nxt = IDLE;
                default:         state_nxt = ERROR;
            endcase
        end
    end

    always_comb begin
        ready = (state == IDLE);
        full  = (sp == SP_W'(DEPTH));
        empty = (sp == '0);
        depth = sp;
    end

    // Memory-side strobes are registered so they stay flat across the falling
    // edge on which the memory samples them.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp          <= '0;
            err         <= ERR_NONE;
            mem_we      <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            pop_data    <= '0;
            pop_valid   <= 1'b0;
        end else begin
            pop_valid <= 1'b0;
            if (clear) begin
                sp     <= '0;
                err    <= ERR_NONE;
                mem_we <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (push && pop) begin
                            err <= ERR_CONF;
                        end else if (push) begin
                            if (full) begin
                                err <= ERR_OVF;
                            end else begin
                                mem_address <= ADDR_W'(sp);
                                mem_data    <= push_data;
                                mem_we      <= 1'b1;
                            end
                        end else if (pop) begin
                            if (empty) err <= ERR_UDF;
                            else       mem_address <= ADDR_W'(sp - 1'b1);
                        end
                    end
                    PUSH_WR: begin
                        mem_we <= 1'b0;
                        sp     <= sp + 1'b1;
                    end
                    POP_RD: begin
                        pop_data  <= mem_rdata;
                        pop_valid <= 1'b1;
                        sp        <= sp - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
